// File: rtl/device_info_collector.sv
// Per-run statistics collector for the stream-join kernel; optional stall counter under `DEVICE_INFO_STALL_CNT_EN.
// Latency: wr_start pulses one cycle after run_finish; ctrl_done pulses one cycle after wr_done.
// Backpressure: none on the event strobes; holds the record stable in S_WAIT until the write master reports wr_done.
module device_info_collector #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_CNT_WIDTH        = 64
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          run_start,
    input  logic                          run_finish,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] run_addr_offset,
    input  logic                          tuple_valid,
    input  logic                          result_valid,
    input  logic                          stall_valid,
    output logic                          wr_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_offset,
    output logic [C_M_AXI_DATA_WIDTH-1:0] wr_device_info,
    input  logic                          wr_done,
    output logic                          busy,
    output logic                          ctrl_done
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_ISSUE, S_WAIT} state_t;

    localparam logic [31:0]            MAGIC   = 32'h464A_4F49;
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

    state_t state, state_nxt;

    logic [C_CNT_WIDTH-1:0] cycle_cnt, tuple_cnt, result_cnt;
    logic [C_CNT_WIDTH-1:0] cycle_nxt, tuple_nxt, result_nxt;
    logic [63:0]            stall_field;
    logic [31:0]            run_id;
    logic [C_M_AXI_DATA_WIDTH-1:0] packed_word;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
    endfunction

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; run_finish in S_IDLE and run_start outside S_IDLE are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run_start)  state_nxt = S_COUNT;
            S_COUNT: if (run_finish) state_nxt = S_ISSUE;
            S_ISSUE:                 state_nxt = S_WAIT;
            S_WAIT:  if (wr_done)    state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state, so they clear immediately on reset.
    always_comb begin
        busy     = (state != S_IDLE);
        wr_start = (state == S_ISSUE);
    end

    // Counter values including this cycle's events; used both to update and to snapshot on run_finish.
    always_comb begin
        cycle_nxt  = sat_inc(cycle_cnt, 1'b1);
        tuple_nxt  = sat_inc(tuple_cnt, tuple_valid);
        result_nxt = sat_inc(result_cnt, result_valid);
    end

`ifdef DEVICE_INFO_STALL_CNT_EN
    logic [C_CNT_WIDTH-1:0] stall_cnt, stall_nxt;

    // Stall counter next value.
    always_comb stall_nxt = sat_inc(stall_cnt, stall_valid);

    // Stall counter: cleared on run start, counts in S_COUNT.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                          stall_cnt <= '0;
        else if (state == S_IDLE && run_start) stall_cnt <= '0;
        else if (state == S_COUNT)           stall_cnt <= stall_nxt;
    end

    // Zero-extended stall field.
    always_comb stall_field = 64'(stall_nxt);
`else
    logic unused_stall;
    assign unused_stall = stall_valid;

    // No stall counter in this build: the field reads as zero.
    always_comb stall_field = 64'd0;
`endif

    // Pack the record LSB first; counters are zero-extended to 64-bit fields.
    always_comb begin
        packed_word          = '0;
        packed_word[63:0]    = 64'(cycle_nxt);
        packed_word[127:64]  = 64'(tuple_nxt);
        packed_word[191:128] = 64'(result_nxt);
        packed_word[255:192] = stall_field;
        packed_word[287:256] = MAGIC;
        packed_word[319:288] = run_id;
    end

    // Statistic counters and destination address latch.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cycle_cnt      <= '0;
            tuple_cnt      <= '0;
            result_cnt     <= '0;
            wr_addr_offset <= '0;
        end else if (state == S_IDLE && run_start) begin
            cycle_cnt      <= '0;
            tuple_cnt      <= '0;
            result_cnt     <= '0;
            wr_addr_offset <= run_addr_offset;
        end else if (state == S_COUNT) begin
            cycle_cnt      <= cycle_nxt;
            tuple_cnt      <= tuple_nxt;
            result_cnt     <= result_nxt;
        end
    end

    // Snapshot the record at run_finish; it stays frozen until the next run finishes.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                             wr_device_info <= '0;
        else if (state == S_COUNT && run_finish) wr_device_info <= packed_word;
    end

    // Completion pulse and run numbering; wr_done only counts while waiting for it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ctrl_done <= 1'b0;
            run_id    <= '0;
        end else begin
            ctrl_done <= (state == S_WAIT) && wr_done;
            if (state == S_WAIT && wr_done) run_id <= run_id + 32'd1;
        end
    end

endmodule

// File: tb/tb_device_info_collector.sv
// Directed bench for device_info_collector: a default-width instance and a 4-bit-counter instance share stimulus.
// Inputs change #1 after the rising edge; outputs are checked in the same window.
// Expected records are built locally from hand-computed field values.
module tb_device_info_collector;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        areset, run_start, run_finish, tuple_valid, result_valid, stall_valid, wr_done;
    logic [63:0] run_addr_offset;

    logic        wr_start, busy, ctrl_done;
    logic [63:0] wr_addr_offset;
    logic [511:0] wr_device_info;

    logic        wr_start_s, busy_s, ctrl_done_s;
    logic [63:0] wr_addr_offset_s;
    logic [511:0] wr_device_info_s;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] A1 = 64'h0000_0010_0000_0040;
    localparam logic [63:0] A2 = 64'h0000_0020_0000_0080;
    localparam logic [63:0] A3 = 64'hDEAD_0000_0000_00C0;
`ifdef DEVICE_INFO_STALL_CNT_EN
    localparam logic [63:0] EXP_STALL = 64'd7;
`else
    localparam logic [63:0] EXP_STALL = 64'd0;
`endif

    device_info_collector dut (
        .aclk(aclk), .areset(areset), .run_start(run_start), .run_finish(run_finish),
        .run_addr_offset(run_addr_offset), .tuple_valid(tuple_valid), .result_valid(result_valid),
        .stall_valid(stall_valid), .wr_start(wr_start), .wr_addr_offset(wr_addr_offset),
        .wr_device_info(wr_device_info), .wr_done(wr_done), .busy(busy), .ctrl_done(ctrl_done)
    );

    device_info_collector #(.C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(512), .C_CNT_WIDTH(4)) dut_s (
        .aclk(aclk), .areset(areset), .run_start(run_start), .run_finish(run_finish),
        .run_addr_offset(run_addr_offset), .tuple_valid(tuple_valid), .result_valid(result_valid),
        .stall_valid(stall_valid), .wr_start(wr_start_s), .wr_addr_offset(wr_addr_offset_s),
        .wr_device_info(wr_device_info_s), .wr_done(wr_done), .busy(busy_s), .ctrl_done(ctrl_done_s)
    );

    function automatic logic [511:0] mkword(input logic [63:0] c, input logic [63:0] t,
                                            input logic [63:0] r, input logic [63:0] s,
                                            input logic [31:0] id);
        return {192'd0, id, 32'h464A_4F49, s, r, t, c};
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset = 1'b1; run_start = 1'b0; run_finish = 1'b0; tuple_valid = 1'b0;
        result_valid = 1'b0; stall_valid = 1'b0; wr_done = 1'b0; run_addr_offset = '0;
        repeat (3) tick();
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_wr_start", 512'(wr_start), 512'(0));
        chk("rst_ctrl_done", 512'(ctrl_done), 512'(0));
        chk("rst_word", wr_device_info, 512'(0));
        chk("rst_addr", 512'(wr_addr_offset), 512'(0));
        areset = 1'b0;
        tick();
        chk("post_rst_busy", 512'(busy), 512'(0));

        // run_finish while idle must not issue anything
        run_finish = 1'b1;
        tick();
        run_finish = 1'b0;
        chk("idle_finish_busy", 512'(busy), 512'(0));
        tick();
        chk("idle_finish_wr_start", 512'(wr_start), 512'(0));

        // Run 1: start at edge 0 with a coincident (ignored) run_finish
        run_start = 1'b1; run_finish = 1'b1; run_addr_offset = A1;
        tick();
        run_start = 1'b0; run_finish = 1'b0; run_addr_offset = '0;
        chk("r1_busy", 512'(busy), 512'(1));
        chk("r1_addr", 512'(wr_addr_offset), 512'(A1));
        chk("r1_no_early_start", 512'(wr_start), 512'(0));
        for (int e = 1; e <= 10; e++) begin
            tuple_valid     = (e <= 5);
            result_valid    = (e == 3 || e == 4);
            stall_valid     = (e <= 7);
            run_start       = (e == 2);
            run_addr_offset = (e == 2) ? A3 : 64'd0;
            wr_done         = (e == 6);
            run_finish      = (e == 10);
            tick();
            if (e == 6) chk("r1_stray_done_busy", 512'(busy), 512'(1));
            if (e == 6) chk("r1_stray_done_wr_start", 512'(wr_start), 512'(0));
        end
        tuple_valid = 1'b0; result_valid = 1'b0; stall_valid = 1'b0;
        run_start = 1'b0; run_addr_offset = '0; wr_done = 1'b0; run_finish = 1'b0;
        chk("r1_wr_start", 512'(wr_start), 512'(1));
        chk("r1_word", wr_device_info, mkword(64'd10, 64'd5, 64'd2, EXP_STALL, 32'd0));
        chk("r1_addr_issue", 512'(wr_addr_offset), 512'(A1));
        chk("r1_word_narrow", wr_device_info_s, mkword(64'd10, 64'd5, 64'd2, EXP_STALL, 32'd0));
        tick();
        chk("r1_wr_start_one_cycle", 512'(wr_start), 512'(0));
        chk("r1_wait_busy", 512'(busy), 512'(1));
        chk("r1_wait_word", wr_device_info, mkword(64'd10, 64'd5, 64'd2, EXP_STALL, 32'd0));
        tick();
        chk("r1_wait_addr", 512'(wr_addr_offset), 512'(A1));
        chk("r1_wait_no_done", 512'(ctrl_done), 512'(0));
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("r1_done_busy", 512'(busy), 512'(0));
        chk("r1_ctrl_done", 512'(ctrl_done), 512'(1));

        // Run 2 starts at the earliest edge; tuples saturate in the 4-bit instance
        run_start = 1'b1; run_addr_offset = A2;
        tick();
        run_start = 1'b0; run_addr_offset = '0;
        chk("r2_busy", 512'(busy), 512'(1));
        chk("r2_ctrl_done_pulse", 512'(ctrl_done), 512'(0));
        chk("r2_addr", 512'(wr_addr_offset), 512'(A2));
        for (int e = 1; e <= 20; e++) begin
            tuple_valid = 1'b1;
            run_finish  = (e == 20);
            tick();
        end
        tuple_valid = 1'b0; run_finish = 1'b0;
        chk("r2_wr_start", 512'(wr_start), 512'(1));
        chk("r2_word", wr_device_info, mkword(64'd20, 64'd20, 64'd0, 64'd0, 32'd1));
        chk("r2_word_sat", wr_device_info_s, mkword(64'd15, 64'd15, 64'd0, 64'd0, 32'd1));
        tick();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("r2_ctrl_done", 512'(ctrl_done), 512'(1));

        // Run 3: reset while waiting for the write master
        tick();
        run_start = 1'b1; run_addr_offset = A3;
        tick();
        run_start = 1'b0; run_addr_offset = '0;
        repeat (3) tick();
        run_finish = 1'b1;
        tick();
        run_finish = 1'b0;
        chk("r3_wr_start", 512'(wr_start), 512'(1));
        tick();
        chk("r3_wait_busy", 512'(busy), 512'(1));
        #2 areset = 1'b1;
        #1;
        chk("r3_rst_busy", 512'(busy), 512'(0));
        chk("r3_rst_wr_start", 512'(wr_start), 512'(0));
        chk("r3_rst_ctrl_done", 512'(ctrl_done), 512'(0));
        chk("r3_rst_word", wr_device_info, 512'(0));
        chk("r3_rst_addr", 512'(wr_addr_offset), 512'(0));
        tick();
        areset = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("r3_late_done_ctrl", 512'(ctrl_done), 512'(0));
        chk("r3_late_done_busy", 512'(busy), 512'(0));
        tick();
        chk("r3_late_done_ctrl2", 512'(ctrl_done), 512'(0));

        // Run 4: run_id restarts from 0 after reset
        run_start = 1'b1; run_addr_offset = A1;
        tick();
        run_start = 1'b0; run_addr_offset = '0;
        for (int e = 1; e <= 2; e++) begin
            run_finish = (e == 2);
            tick();
        end
        run_finish = 1'b0;
        chk("r4_word", wr_device_info, mkword(64'd2, 64'd0, 64'd0, 64'd0, 32'd0));
        chk("r4_addr", 512'(wr_addr_offset), 512'(A1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/device_info_collector.md
# device_info_collector

- Collects per-run statistics for the stream-join kernel: cycles, input tuples, join results and optional stall cycles.
- Packs them into one 512-bit device-info word.
- Hands the word and a target address to the downstream single-beat AXI write master through a start/done handshake.
- Sits between the join datapath event strobes and the device-info write master.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 64, address width passed downstream
- C_M_AXI_DATA_WIDTH, 512, device-info word width; must be ≥ 320
- C_CNT_WIDTH, 64, width of each statistic counter; must be ≤ 64

Ports (one clock; reset is asynchronous and active-high):
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- run_start  in  1  one-cycle pulse, begin a measurement run
- run_finish  in  1  one-cycle pulse, end the run and publish
- run_addr_offset  in  C_M_AXI_ADDR_WIDTH  destination address, sampled on accepted run_start
- tuple_valid  in  1  one input tuple consumed this cycle
- result_valid  in  1  one join result emitted this cycle
- stall_valid  in  1  datapath stalled this cycle
- wr_start  out  1  one-cycle start pulse to write master
- wr_addr_offset  out  C_M_AXI_ADDR_WIDTH  address to write master
- wr_device_info  out  C_M_AXI_DATA_WIDTH  packed word to write master
- wr_done  in  1  write master completion pulse
- busy  out  1  high in any state except S_IDLE
- ctrl_done  out  1  one-cycle pulse when the record is written

## Operation
- States: S_IDLE, S_COUNT, S_ISSUE, S_WAIT.
- S_IDLE:
  - run_start moves to S_COUNT.
  - On that edge, clear cycle, tuple, result and stall counters and latch run_addr_offset.
  - run_finish is ignored in S_IDLE, including when it coincides with run_start.
- S_COUNT:
  - Every cycle: cycle counter +1; tuple/result/stall counters +1 when their strobe is high.
  - Counters saturate at all-ones and never wrap.
  - run_finish includes that cycle's increments. On the same edge it snapshots the packed word into the wr_device_info register and moves to S_ISSUE.
  - run_start is ignored in S_COUNT.
- S_ISSUE: drive wr_start=1 for exactly one cycle, then move to S_WAIT.
- S_WAIT:
  - wr_device_info and wr_addr_offset are held stable.
  - wr_done moves to S_IDLE, pulses ctrl_done on the next cycle, and increments run_id by 1 (32-bit, wraps).
- wr_done outside S_WAIT is ignored.
- Packing, LSB first:
  - [63:0] cycles
  - [127:64] tuples
  - [191:128] results
  - [255:192] stalls
  - [287:256] magic 32'h464A_4F49
  - [319:288] run_id of the current run
  - remaining bits 0
- Counters narrower than 64 are zero-extended.

## Timing
- Reset values: all outputs 0; state S_IDLE; counters 0; run_id 0.
- run_start at edge N: busy=1 from N+1; the first counted cycle is N+1.
- run_finish at edge M (in S_COUNT): cycles field = M−N. wr_start is high during cycle M+1.
- wr_done sampled at edge K: busy=0 and ctrl_done=1 during cycle K+1.
- Earliest next accepted run_start is at edge K+1.
- Reset asserted mid-run:
  - Immediately return to S_IDLE and zero all outputs; no partial record is issued.
  - A wr_done from an in-flight downstream write arriving after reset is ignored.

## Configuration
- DEVICE_INFO_STALL_CNT_EN defined: stall counter is implemented and fills [255:192].
- Undefined: no stall counter; stall_valid is ignored; [255:192] is 0.

## Test plan
- Basic run: run_start at cycle 0; tuple_valid high cycles 1–5; result_valid high cycles 3–4; run_finish at cycle 10 → one wr_start at cycle 11; word has cycles=10, tuples=5, results=2, magic correct, run_id=0; wr_done → ctrl_done next cycle.
- Back-to-back runs: second run gives run_id=1; counters restart from 0; start address is the second run_addr_offset.
- Saturation: C_CNT_WIDTH=4, tuple_valid high for 20 cycles → tuples field = 15.
- Ignored events:
  - run_finish in S_IDLE → no wr_start.
  - run_start during S_COUNT → counters not cleared.
  - Stray wr_done in S_COUNT → no effect.
- Reset mid-S_WAIT: assert areset → busy=0, wr_start=0, no ctrl_done; a following wr_done is ignored.
- Macro: with DEVICE_INFO_STALL_CNT_EN, 7 stall cycles → stalls=7; without it, same stimulus → [255:192]=0.
